// File: rtl/nco_pkg.sv
// nco_pkg: waveform mode encoding and quarter-wave sine ROM contents
package nco_pkg;
  typedef enum logic [1:0] {WM_SINE, WM_SQUARE, WM_SAW, WM_TRI} wave_mode_e;
  function automatic int quarter_sine(int k, int lut_aw, int out_w);
    real x, term, s;
    x = 1.5707963267948966 * (k + 0.5) / (2.0 ** lut_aw);
    term = x;
    s = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / ((2 * n) * (2 * n + 1));
      s += term;
    end
    return $rtoi((2.0 ** (out_w - 1) - 1.0) * s + 0.5);
  endfunction
endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: quarter-wave sine ROM with enabled synchronous read
module nco_quarter_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);
  logic [OUT_W-2:0] rom [2**LUT_AW];
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    localparam logic [OUT_W-2:0] V = (OUT_W-1)'(quarter_sine(i, LUT_AW, OUT_W));
    assign rom[i] = V;
  end
  always_ff @(posedge clk)
    if (en) data <= rom[addr];
endmodule

// File: rtl/nco_wavegen.sv
// nco_wavegen: phase-accumulator NCO with sine/square/saw/triangle, gain and valid/ready output
module nco_wavegen
  import nco_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W = 10,
  parameter int AMP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [PHASE_W-1:0]      tuning_word,
  input  logic [1:0]              mode,
  input  logic [AMP_W-1:0]        amp,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_wrap
);
  localparam int PW = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam int MW = OUT_W + AMP_W + 1;
  localparam logic signed [OUT_W-1:0] A_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] A_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [MW-1:0] S_MAX = MW'(A_MAX);
  localparam logic signed [MW-1:0] S_MIN = MW'(A_MIN);
  logic [PHASE_W-1:0] acc, tw_reg, acc_next;
  logic carry, wrap_pend, adv, inject;
  logic s1_valid, s1_wrap, s2_valid, s2_wrap, s2_neg, s3_valid, s3_wrap;
  logic [PW-1:0] s1_phase;
  wave_mode_e s1_mode, s2_mode;
  logic [AMP_W-1:0] s1_amp, s2_amp, s3_amp;
  logic [LUT_AW-1:0] k, lut_addr;
  logic [OUT_W-2:0] rom_q;
  logic [OUT_W-1:0] tri_t;
  logic signed [OUT_W-1:0] shape_raw, s2_raw, s3_raw, rom_s, sine_raw, sat;
  logic signed [MW-1:0] prod, scaled;
  assign adv = !out_valid | out_ready;
  assign inject = en & adv;
  assign {carry, acc_next} = {1'b0, acc} + {1'b0, tw_reg};
  assign k = s1_phase[PW-3 -: LUT_AW];
  assign lut_addr = s1_phase[PW-2] ? ~k : k;
  assign tri_t = s1_phase[PW-2 -: OUT_W] ^ {OUT_W{s1_phase[PW-1]}};
  assign rom_s = {1'b0, rom_q};
  always_comb begin
    shape_raw = s1_mode == WM_SQUARE ? (s1_phase[PW-1] ? -A_MAX : A_MAX)
              : s1_mode == WM_SAW ? {~s1_phase[PW-1], s1_phase[PW-2 -: OUT_W-1]}
              : {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
    sine_raw = s2_neg ? -rom_s : rom_s;
    prod = MW'(s3_raw) * MW'($signed({1'b0, s3_amp}));
    scaled = prod >>> (AMP_W - 1);
    sat = scaled > S_MAX ? A_MAX : scaled < S_MIN ? A_MIN : scaled[OUT_W-1:0];
  end
  nco_quarter_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
    .clk (clk),
    .en  (adv),
    .addr(lut_addr),
    .data(rom_q)
  );
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      tw_reg <= '0;
      wrap_pend <= 1'b0;
    end else begin
      if (load) tw_reg <= tuning_word;
      if (inject) begin
        acc <= acc_next;
        wrap_pend <= carry;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_wrap <= 1'b0;
      s1_phase <= '0;
      s1_mode <= WM_SINE;
      s1_amp <= '0;
      s2_valid <= 1'b0;
      s2_wrap <= 1'b0;
      s2_neg <= 1'b0;
      s2_mode <= WM_SINE;
      s2_amp <= '0;
      s2_raw <= '0;
      s3_valid <= 1'b0;
      s3_wrap <= 1'b0;
      s3_amp <= '0;
      s3_raw <= '0;
      out_valid <= 1'b0;
      out_wrap <= 1'b0;
      out <= '0;
    end else if (adv) begin
      s1_valid <= en;
      s1_wrap <= wrap_pend;
      s1_phase <= acc[PHASE_W-1 -: PW];
      s1_mode <= wave_mode_e'(mode);
      s1_amp <= amp;
      s2_valid <= s1_valid;
      s2_wrap <= s1_wrap;
      s2_neg <= s1_phase[PW-1];
      s2_mode <= s1_mode;
      s2_amp <= s1_amp;
      s2_raw <= shape_raw;
      s3_valid <= s2_valid;
      s3_wrap <= s2_wrap;
      s3_amp <= s2_amp;
      s3_raw <= s2_mode == WM_SINE ? sine_raw : s2_raw;
      out_valid <= s3_valid;
      out_wrap <= s3_wrap;
      out <= sat;
    end
endmodule

// File: tb/tb_nco_wavegen.sv
// tb_nco_wavegen: randomized and directed checks of nco_wavegen against a sample-level reference model
module tb_nco_wavegen;
  logic clk = 1'b0;
  logic rst, en, load, out_ready, out_valid, out_wrap;
  logic [23:0] tuning_word;
  logic [1:0] mode;
  logic [7:0] amp;
  logic signed [9:0] out;
  int n_vec = 0, n_err = 0, cyc = 0, inj = 0, first_valid = -1;
  logic [23:0] m_acc, m_tw;
  bit m_wp, m_zero;
  bit pv[4], pw[4];
  int pval[4];
  int got[$];
  bit got_w[$];
  always #5 clk = ~clk;
  nco_wavegen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .tuning_word(tuning_word),
    .mode       (mode),
    .amp        (amp),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out        (out),
    .out_wrap   (out_wrap)
  );
  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic int rom_ref(int k);
    return $rtoi(511.0 * $sin(3.14159265358979 / 2.0 * (k + 0.5) / 256.0) + 0.5);
  endfunction
  function automatic int ref_sample(logic [23:0] ph, logic [1:0] md, logic [7:0] a);
    int raw, k, t, s;
    k = int'(ph[21:14]);
    t = int'(ph[22:13]);
    case (md)
      2'd0: raw = (ph[23] ? -1 : 1) * rom_ref(ph[22] ? 255 - k : k);
      2'd1: raw = ph[23] ? -511 : 511;
      2'd2: raw = int'(ph[23:14]) - 512;
      default: raw = (ph[23] ? 1023 - t : t) - 512;
    endcase
    s = (raw * int'(a)) >>> 7;
    return s > 511 ? 511 : s < -512 ? -512 : s;
  endfunction
  task automatic cycle();
    bit adv;
    @(posedge clk);
    cyc++;
    adv = !pv[3] || out_ready;
    m_zero = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] = 1'b0;
        pw[i] = 1'b0;
        pval[i] = 0;
      end
      m_acc = '0;
      m_tw = '0;
      m_wp = 1'b0;
      m_zero = 1'b1;
    end else begin
      if (adv) begin
        for (int i = 3; i > 0; i--) begin
          pv[i] = pv[i-1];
          pw[i] = pw[i-1];
          pval[i] = pval[i-1];
        end
        pv[0] = en;
        pw[0] = m_wp;
        pval[0] = ref_sample(m_acc, mode, amp);
        if (en) {m_wp, m_acc} = {1'b0, m_acc} + {1'b0, m_tw};
      end
      if (load) m_tw = tuning_word;
    end
    @(negedge clk);
    check("out_valid", int'(out_valid), int'(pv[3]));
    if (pv[3] || m_zero) begin
      check("out", int'(out), m_zero ? 0 : pval[3]);
      check("out_wrap", int'(out_wrap), m_zero ? 0 : int'(pw[3]));
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      got.push_back(int'(out));
      got_w.push_back(out_wrap);
    end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    out_ready = 1'b1;
    tuning_word = '0;
    mode = 2'd0;
    amp = 8'd128;
    repeat (2) cycle();
    rst = 1'b0;
    load = 1'b1;
    tuning_word = 24'h40_0000;
    cycle();
    load = 1'b0;
    got.delete();
    got_w.delete();
    first_valid = -1;
    en = 1'b1;
    inj = cyc + 1;
    repeat (20) cycle();
    check("t1_latency", first_valid - inj, 3);
    check("t1_s0", got[0], 2);
    check("t1_s1", got[1], 511);
    check("t1_s2", got[2], -2);
    check("t1_s3", got[3], -511);
    check("t1_s4", got[4], 2);
    check("t1_w0", int'(got_w[0]), 0);
    check("t1_w3", int'(got_w[3]), 0);
    check("t1_w4", int'(got_w[4]), 1);
    check("t1_w8", int'(got_w[8]), 1);
    amp = 8'd255;
    repeat (20) cycle();
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (10) cycle();
    mode = 2'd2;
    amp = 8'd128;
    load = 1'b1;
    tuning_word = 24'h00_4000;
    cycle();
    load = 1'b0;
    repeat (1100) cycle();
    mode = 2'd1;
    amp = 8'd64;
    repeat (1100) cycle();
    mode = 2'd0;
    amp = 8'd128;
    load = 1'b1;
    tuning_word = 24'h10_0000;
    cycle();
    load = 1'b0;
    repeat (8) cycle();
    en = 1'b0;
    repeat (6) cycle();
    check("t5_drained", int'(out_valid), 0);
    en = 1'b1;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_out", int'(out), 0);
    rst = 1'b0;
    got.delete();
    got_w.delete();
    load = 1'b1;
    tuning_word = 24'h40_0000;
    cycle();
    load = 1'b0;
    repeat (6) cycle();
    check("t6_first", got[0], 2);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 19) == 0);
      tuning_word = 24'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) amp = 8'($urandom);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
